// File: rtl/tdm_demux_2ch.sv
// Receive side of a 2:1 TDM serial link: aligns to a sync marker and
// rebuilds one WIDTH-bit word per channel from the interleaved bit stream.
module tdm_demux_2ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             demux_in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] ch0_out,
    output logic [WIDTH-1:0] ch1_out,
    output logic             out_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int             CW       = $clog2(2 * WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(2 * WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

    state_e             state_q,     state_d;
    logic [CW-1:0]      cnt_q,       cnt_d;
    logic [WIDTH-1:0]   sh0_q,       sh0_d;
    logic [WIDTH-1:0]   sh1_q,       sh1_d;
    logic [WIDTH-1:0]   ch0_q,       ch0_d;
    logic [WIDTH-1:0]   ch1_q,       ch1_d;
    logic               out_valid_q, out_valid_d;
    logic               sync_err_q,  sync_err_d;

    // Words arrive LSB first, so each channel shifts in from the top; after
    // WIDTH shifts the first bit of the frame sits in bit 0.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        ch0_d       = ch0_q;
        ch1_d       = ch1_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        state_d = LOCKED;
                        cnt_d   = CNT_ONE;
                        sh0_d   = {demux_in, {(WIDTH-1){1'b0}}};
                        sh1_d   = '0;
                    end
                end
                LOCKED: begin
                    if (sync && cnt_q != '0) begin
                        // Realign: drop the partial frame, this bit starts a new one.
                        sync_err_d = 1'b1;
                        cnt_d      = CNT_ONE;
                        sh0_d      = {demux_in, {(WIDTH-1){1'b0}}};
                        sh1_d      = '0;
                    end else begin
                        if (cnt_q[0]) begin
                            sh1_d = {demux_in, sh1_q[WIDTH-1:1]};
                        end else begin
                            sh0_d = {demux_in, sh0_q[WIDTH-1:1]};
                        end
                        if (cnt_q == CNT_LAST) begin
                            ch0_d       = sh0_d;
                            ch1_d       = sh1_d;
                            out_valid_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            ch0_q       <= '0;
            ch1_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            ch0_q       <= ch0_d;
            ch1_q       <= ch1_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign ch0_out   = ch0_q;
    assign ch1_out   = ch1_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Bench for tdm_demux_2ch: directed scenarios plus random traffic, checked
// every cycle against a frame-queue model of the link.
module tb_tdm_demux_2ch;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         demux_in;
    logic         in_valid;
    logic         sync;
    logic [W-1:0] ch0_out;
    logic [W-1:0] ch1_out;
    logic         out_valid;
    logic         locked;
    logic         sync_err;

    tdm_demux_2ch #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .demux_in  (demux_in),
        .in_valid  (in_valid),
        .sync      (sync),
        .ch0_out   (ch0_out),
        .ch1_out   (ch1_out),
        .out_valid (out_valid),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits of the current frame go in a queue once aligned; a full
    // queue of 2*W bits is split into even/odd positions for ch0/ch1.
    bit           m_aligned;
    bit           frame[$];
    logic [W-1:0] e_ch0, e_ch1;
    logic         e_ov, e_err, e_lock;

    always @(posedge clk) begin
        if (rst) begin
            m_aligned = 1'b0;
            frame.delete();
            e_ch0 = '0; e_ch1 = '0; e_ov = 1'b0; e_err = 1'b0; e_lock = 1'b0;
        end else begin
            e_ov  = 1'b0;
            e_err = 1'b0;
            if (in_valid) begin
                if (sync) begin
                    if (m_aligned && frame.size() != 0) e_err = 1'b1;
                    frame.delete();
                    m_aligned = 1'b1;
                end
                if (m_aligned) begin
                    frame.push_back(demux_in);
                    if (frame.size() == 2 * W) begin
                        for (int i = 0; i < 2 * W; i++) begin
                            if (i % 2 == 0) e_ch0[i/2] = frame[i];
                            else            e_ch1[i/2] = frame[i];
                        end
                        e_ov = 1'b1;
                        frame.delete();
                    end
                end
            end
            e_lock = m_aligned;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ch0_out",   ch0_out,   e_ch0);
            check("ch1_out",   ch1_out,   e_ch1);
            check("out_valid", out_valid, e_ov);
            check("locked",    locked,    e_lock);
            check("sync_err",  sync_err,  e_err);
        end
    end

    // Pulse bookkeeping, measured in accepted bits.
    int acc_cnt = 0, last_acc = 0, pulse_gap = 0, pulses = 0;

    always @(posedge clk) begin
        if (!rst && in_valid) acc_cnt++;
    end

    always @(negedge clk) begin
        if (chk_en && out_valid === 1'b1) begin
            pulse_gap = acc_cnt - last_acc;
            last_acc  = acc_cnt;
            pulses++;
        end
    end

    task automatic drive(input logic v, input logic b, input logic s);
        in_valid = v;
        demux_in = b;
        sync     = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input int lo, input int hi, input logic sync_lo,
                              input int gap_a, input int gap_b);
        logic b;
        for (int i = lo; i <= hi; i++) begin
            b = (i % 2 != 0) ? w1[i/2] : w0[i/2];
            drive(1'b1, b, sync_lo && (i == lo));
            if (i == gap_a || i == gap_b) repeat (3) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    int p0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; demux_in = 1'b0; sync = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("reset_locked", locked, 1'b0);
        check("reset_ch0", ch0_out, 8'h00);
        rst = 1'b0;

        // Basic frame with sync on the first bit.
        send_range(8'hA5, 8'h3C, 0, 15, 1'b1, -1, -1);
        check("basic_ch0", ch0_out, 8'hA5);
        check("basic_ch1", ch1_out, 8'h3C);
        check("basic_ov", out_valid, 1'b1);
        check("model_ch0", e_ch0, 8'hA5);
        drive(1'b0, 1'b0, 1'b0);
        check("basic_ov_drop", out_valid, 1'b0);
        check("basic_pulses", pulses, 1);

        // Flywheel: second frame carries no sync.
        send_range(8'hA5, 8'h3C, 0, 15, 1'b1, -1, -1);
        send_range(8'h5A, 8'hC3, 0, 15, 1'b0, -1, -1);
        check("fly_ch0", ch0_out, 8'h5A);
        check("fly_ch1", ch1_out, 8'hC3);
        drive(1'b0, 1'b0, 1'b0);
        check("fly_gap", pulse_gap, 16);
        check("fly_pulses", pulses, 3);

        // Gaps of 3 idle cycles after accepted bits 5 and 11.
        p0 = pulses;
        send_range(8'hA5, 8'h3C, 0, 15, 1'b1, 4, 10);
        check("gap_ch0", ch0_out, 8'hA5);
        check("gap_ch1", ch1_out, 8'h3C);
        drive(1'b0, 1'b0, 1'b0);
        check("gap_pulses", pulses, p0 + 1);

        // Resync at accepted bit 7 of a frame.
        p0 = pulses;
        send_range(8'h5A, 8'hC3, 0, 5, 1'b0, -1, -1);
        send_range(8'h96, 8'h69, 0, 0, 1'b1, -1, -1);
        check("resync_err", sync_err, 1'b1);
        check("resync_ov", out_valid, 1'b0);
        check("resync_locked", locked, 1'b1);
        send_range(8'h96, 8'h69, 1, 15, 1'b0, -1, -1);
        check("resync_ch0", ch0_out, 8'h96);
        check("resync_ch1", ch1_out, 8'h69);
        drive(1'b0, 1'b0, 1'b0);
        check("resync_pulses", pulses, p0 + 1);

        // Mid-stream reset, then bits without sync.
        send_range(8'h5A, 8'hC3, 0, 4, 1'b1, -1, -1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("rst_ch0", ch0_out, 8'h00);
        check("rst_ch1", ch1_out, 8'h00);
        check("rst_locked", locked, 1'b0);
        rst = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom), 1'b0);
        check("nosync_locked", locked, 1'b0);
        check("nosync_pulses", pulses, p0);

        // Sync with in_valid low must not lock.
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        check("idle_sync_locked", locked, 1'b0);
        send_range(8'h3C, 8'hA5, 0, 0, 1'b1, -1, -1);
        check("first_sync_locked", locked, 1'b1);
        send_range(8'h3C, 8'hA5, 1, 15, 1'b0, -1, -1);
        check("lock_ch0", ch0_out, 8'h3C);

        // Random traffic checked by the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic v, s;
            rst = ($urandom_range(0, 999) == 0);
            v   = ($urandom_range(0, 9) < 7);
            s   = v ? ($urandom_range(0, 39) == 0) : 1'($urandom);
            drive(v, 1'($urandom), s);
        end
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
